link_session_ctrl: RTL and testbench

- Sequences the PC–board link over the FT245 byte path.
- Flow: detect "UTN" from gr-serializer, reply "UTNv2", receive the 16-bit sample rate, validate it, reply "OK" or "ERR".
- On "OK", hands the receive path to the sample datapath and supervises it with a sample watchdog.
- Sits between the FT245 byte RX/TX engines and the DAC sample path.

---
 rtl/link_pkg.sv | 85 ++++++++
 rtl/link_session_ctrl_hs_tx_seq.sv | 91 +++++++++
 rtl/link_session_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_link_session_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants, FSM encoding, rate table and reply strings
// for the PC-board link session controller.
package link_pkg;

  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_V = 8'h76;
  localparam logic [7:0] CH_2 = 8'h32;
  localparam logic [7:0] CH_O = 8'h4F;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GOT_U,
    S_GOT_T,
    S_TX_HELLO,
    S_RX_RATE_H,
    S_RX_RATE_L,
    S_CHECK,
    S_TX_OK,
    S_TX_ERR,
    S_STREAM
  } state_e;

  typedef enum logic [1:0] {
    STR_HELLO,
    STR_OK,
    STR_ERR
  } str_e;

  function automatic logic [15:0] rate_hz(
    input logic [2:0] idx
  );
    logic [15:0] r;
    unique case (idx)
      3'd0: r = 16'd48000;
      3'd1: r = 16'd44100;
      3'd2: r = 16'd32000;
      3'd3: r = 16'd24000;
      3'd4: r = 16'd22050;
      3'd5: r = 16'd16000;
      3'd6: r = 16'd11025;
      default: r = 16'd8000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] str_len(
    input str_e id
  );
    logic [2:0] n;
    unique case (id)
      STR_HELLO: n = 3'd5;
      STR_OK:    n = 3'd2;
      default:   n = 3'd3;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] str_byte(
    input str_e       id,
    input logic [2:0] idx
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (id)
      STR_HELLO: begin
        unique case (idx)
          3'd0: b = CH_U;
          3'd1: b = CH_T;
          3'd2: b = CH_N;
          3'd3: b = CH_V;
          default: b = CH_2;
        endcase
      end
      STR_OK:  b = (idx == 3'd0) ? CH_O : CH_K;
      default: b = (idx == 3'd0) ? CH_E : CH_R;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/link_session_ctrl_hs_tx_seq.sv
// Sends one reply string byte by byte over the four-phase
// tx_rq/tx_st handshake; pulses done after the last ack drops.
module hs_tx_seq
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  str_e       id_i,
  input  logic       tx_st_s_i,
  output logic       tx_rq_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_ACK
  } ph_e;

  ph_e        ph_q, ph_d;
  str_e       id_q, id_d;
  logic [2:0] idx_q, idx_d;
  logic       rq_q, rq_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q   <= T_IDLE;
      id_q   <= STR_HELLO;
      idx_q  <= 3'd0;
      rq_q   <= 1'b0;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      id_q   <= id_d;
      idx_q  <= idx_d;
      rq_q   <= rq_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    ph_d   = ph_q;
    id_d   = id_q;
    idx_d  = idx_q;
    rq_d   = rq_q;
    data_d = data_q;
    done_d = 1'b0;
    unique case (ph_q)
      T_IDLE: begin
        if (start_i) begin
          id_d   = id_i;
          idx_d  = 3'd0;
          data_d = str_byte(id_i, 3'd0);
          rq_d   = 1'b1;
          ph_d   = T_REQ;
        end
      end
      T_REQ: begin
        if (tx_st_s_i) begin
          rq_d = 1'b0;
          ph_d = T_ACK;
        end
      end
      T_ACK: begin
        if (!tx_st_s_i) begin
          if (idx_q == str_len(id_q) - 3'd1) begin
            done_d = 1'b1;
            ph_d   = T_IDLE;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = str_byte(id_q, idx_q + 3'd1);
            rq_d   = 1'b1;
            ph_d   = T_REQ;
          end
        end
      end
      default: ph_d = T_IDLE;
    endcase
  end

  assign tx_rq_o   = rq_q;
  assign tx_data_o = data_q;
  assign done_o    = done_q;

endmodule

// File: rtl/link_session_ctrl.sv
// Link bring-up: UTN hello, sample-rate negotiation, then
// hand-off to the sample path under a sample watchdog.
module link_session_ctrl
  import link_pkg::*;
#(
  parameter int          CLK_HZ       = 12000000,
  parameter logic [23:0] BYTE_TIMEOUT = 24'(CLK_HZ / 2),
  parameter logic [15:0] WD_TIMEOUT   = 16'(CLK_HZ / 1000),
  parameter logic [24:0] GRACE_CYCLES = 25'(CLK_HZ * 2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rq,
  input  logic [7:0] rx_data,
  output logic       rx_st,
  output logic       tx_rq,
  output logic [7:0] tx_data,
  input  logic       tx_st,
  input  logic       sample_stb,
  output logic       stream_en,
  output logic [2:0] rate_sel,
  output logic       alarm,
  output logic       init_rdy
);

  state_e      state_q, state_d;
  logic        rx_rq_s_q, tx_st_s_q;
  logic        rx_st_q, rx_st_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  rate_hi_q, rate_hi_d;
  logic [7:0]  rate_lo_q, rate_lo_d;
  logic [2:0]  rate_sel_q, rate_sel_d;
  logic        stream_en_q, stream_en_d;
  logic        alarm_q, alarm_d;
  logic        init_rdy_q, init_rdy_d;
  logic [23:0] byte_cnt_q, byte_cnt_d;
  logic [24:0] grace_cnt_q, grace_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic        byte_vld, timed, tmo, armed;
  logic        rate_hit;
  logic [2:0]  rate_idx;
  logic        tx_start, tx_done;
  str_e        tx_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_rq_s_q   <= 1'b0;
      tx_st_s_q   <= 1'b0;
      rx_st_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
      rate_hi_q   <= 8'h00;
      rate_lo_q   <= 8'h00;
      rate_sel_q  <= 3'd0;
      stream_en_q <= 1'b0;
      alarm_q     <= 1'b1;
      init_rdy_q  <= 1'b0;
      byte_cnt_q  <= 24'd0;
      grace_cnt_q <= 25'd0;
      wd_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      rx_rq_s_q   <= rx_rq;
      tx_st_s_q   <= tx_st;
      rx_st_q     <= rx_st_d;
      rx_byte_q   <= rx_byte_d;
      rate_hi_q   <= rate_hi_d;
      rate_lo_q   <= rate_lo_d;
      rate_sel_q  <= rate_sel_d;
      stream_en_q <= stream_en_d;
      alarm_q     <= alarm_d;
      init_rdy_q  <= init_rdy_d;
      byte_cnt_q  <= byte_cnt_d;
      grace_cnt_q <= grace_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  always_comb begin
    rate_hit = 1'b0;
    rate_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ({rate_hi_q, rate_lo_q} == rate_hz(3'(i))) begin
        rate_hit = 1'b1;
        rate_idx = 3'(i);
      end
    end
  end

  // The sample path owns the RX handshake while streaming.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_byte_d = rx_byte_q;
    byte_vld  = 1'b0;
    if (stream_en_q) begin
      rx_st_d = 1'b0;
    end else if (rx_rq_s_q && !rx_st_q) begin
      rx_st_d   = 1'b1;
      rx_byte_d = rx_data;
    end else if (!rx_rq_s_q && rx_st_q) begin
      rx_st_d  = 1'b0;
      byte_vld = 1'b1;
    end
  end

  always_comb begin
    timed = (state_q == S_GOT_U) || (state_q == S_GOT_T) ||
            (state_q == S_RX_RATE_H) ||
            (state_q == S_RX_RATE_L);
    if (!timed || byte_vld) begin
      byte_cnt_d = 24'd0;
    end else if (byte_cnt_q == '1) begin
      byte_cnt_d = byte_cnt_q;
    end else begin
      byte_cnt_d = byte_cnt_q + 24'd1;
    end
    tmo = timed && !byte_vld && (byte_cnt_q >= BYTE_TIMEOUT);
  end

  always_comb begin
    armed       = grace_cnt_q >= GRACE_CYCLES;
    grace_cnt_d = 25'd0;
    wd_cnt_d    = 16'd0;
    if (state_q == S_STREAM) begin
      grace_cnt_d = armed ? grace_cnt_q : grace_cnt_q + 25'd1;
      if (armed && !sample_stb) begin
        wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rate_hi_d   = rate_hi_q;
    rate_lo_d   = rate_lo_q;
    rate_sel_d  = rate_sel_q;
    stream_en_d = stream_en_q;
    alarm_d     = alarm_q;
    init_rdy_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (byte_vld && rx_byte_q == CH_U) state_d = S_GOT_U;
      end
      S_GOT_U: begin
        if (byte_vld) begin
          unique case (1'b1)
            rx_byte_q == CH_T: state_d = S_GOT_T;
            rx_byte_q == CH_U: state_d = S_GOT_U;
            default:           state_d = S_IDLE;
          endcase
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_GOT_T: begin
        if (byte_vld) begin
          unique case (1'b1)
            rx_byte_q == CH_N: state_d = S_TX_HELLO;
            rx_byte_q == CH_U: state_d = S_GOT_U;
            default:           state_d = S_IDLE;
          endcase
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_TX_HELLO: begin
        if (tx_done) state_d = S_RX_RATE_H;
      end
      S_RX_RATE_H: begin
        if (byte_vld) begin
          rate_hi_d = rx_byte_q;
          state_d   = S_RX_RATE_L;
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_RX_RATE_L: begin
        if (byte_vld) begin
          rate_lo_d = rx_byte_q;
          state_d   = S_CHECK;
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (rate_hit) begin
          rate_sel_d = rate_idx;
          state_d    = S_TX_OK;
        end else begin
          state_d = S_TX_ERR;
        end
      end
      S_TX_OK: begin
        if (tx_done) begin
          stream_en_d = 1'b1;
          alarm_d     = 1'b0;
          init_rdy_d  = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_TX_ERR: begin
        if (tx_done) state_d = S_IDLE;
      end
      S_STREAM: begin
        if (armed && wd_cnt_d >= WD_TIMEOUT) begin
          stream_en_d = 1'b0;
          alarm_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kick the string sender on entry to each reply state.
  always_comb begin
    tx_start = 1'b0;
    tx_id    = STR_HELLO;
    if (state_d != state_q) begin
      unique case (state_d)
        S_TX_HELLO: begin
          tx_start = 1'b1;
          tx_id    = STR_HELLO;
        end
        S_TX_OK: begin
          tx_start = 1'b1;
          tx_id    = STR_OK;
        end
        S_TX_ERR: begin
          tx_start = 1'b1;
          tx_id    = STR_ERR;
        end
        default: tx_start = 1'b0;
      endcase
    end
  end

  hs_tx_seq u_tx (
    .clk       (clk),
    .rst       (rst),
    .start_i   (tx_start),
    .id_i      (tx_id),
    .tx_st_s_i (tx_st_s_q),
    .tx_rq_o   (tx_rq),
    .tx_data_o (tx_data),
    .done_o    (tx_done)
  );

  assign rx_st     = rx_st_q;
  assign stream_en = stream_en_q;
  assign rate_sel  = rate_sel_q;
  assign alarm     = alarm_q;
  assign init_rdy  = init_rdy_q;

endmodule

// File: tb/tb_link_session_ctrl.sv
// Bench for link_session_ctrl: vector table plus TX scoreboard
// and hand-written watchdog, timeout and reset sequences.
module tb_link_session_ctrl;

  localparam int BT = 200;
  localparam int WD = 100;
  localparam int GR = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_rq = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_st = 1'b0;
  logic       sample_stb = 1'b0;
  logic       rx_st, tx_rq, stream_en, alarm, init_rdy;
  logic [7:0] tx_data;
  logic [2:0] rate_sel;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int rn;
  logic prev_rq = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  link_session_ctrl #(
    .BYTE_TIMEOUT (24'(BT)),
    .WD_TIMEOUT   (16'(WD)),
    .GRACE_CYCLES (25'(GR))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rq      (rx_rq),
    .rx_data    (rx_data),
    .rx_st      (rx_st),
    .tx_rq      (tx_rq),
    .tx_data    (tx_data),
    .tx_st      (tx_st),
    .sample_stb (sample_stb),
    .stream_en  (stream_en),
    .rate_sel   (rate_sel),
    .alarm      (alarm),
    .init_rdy   (init_rdy)
  );

  typedef struct packed {
    logic [2:0]  nrx;
    logic [31:0] rx;
    logic [2:0]  ntx;
    logic [39:0] tx;
    logic        se;
    logic        al;
    logic [2:0]  rs;
    logic        ir;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: each new TX request must match the queue head.
  always @(negedge clk) begin
    if (tx_rq && !prev_rq) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %02h want none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_rq = tx_rq;
    if (init_rdy) init_cnt++;
  end

  // TX engine model: ack after a short delay, release on rq drop.
  initial forever begin
    @(negedge clk);
    if (tx_rq && rst) begin
      repeat (2) @(negedge clk);
      tx_st = 1'b1;
      rn = 0;
      while (tx_rq && rn < 1000) begin
        @(negedge clk);
        rn++;
      end
      if (tx_rq) begin
        checks++;
        errors++;
        $display("FAIL tx_rq_stuck: got 1 want 0");
      end
      @(negedge clk);
      tx_st = 1'b0;
    end
  end

  task automatic wait_rxst(input logic v);
    int n = 0;
    while (rx_st !== v && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (rx_st !== v) begin
      checks++;
      errors++;
      $display("FAIL rx_st_timeout: got %b want %b", rx_st, v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rq = 1'b1;
    wait_rxst(1'b1);
    rx_rq = 1'b0;
    wait_rxst(1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_rq || tx_st) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL tx_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [2:0] n, input logic [39:0] s);
    for (int j = 0; j < int'(n); j++) exp_q.push_back(s[39-8*j -: 8]);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    init_cnt = 0;
    push_tx(v.ntx, v.tx);
    for (int j = 0; j < int'(v.nrx); j++) send_byte(v.rx[31-8*j -: 8]);
    wait_drain();
    check($sformatf("v%0d stream_en", i), 32'(stream_en), 32'(v.se));
    check($sformatf("v%0d alarm", i), 32'(alarm), 32'(v.al));
    check($sformatf("v%0d rate_sel", i), 32'(rate_sel), 32'(v.rs));
    check($sformatf("v%0d init_rdy", i), 32'(init_cnt), 32'(v.ir));
  endtask

  localparam logic [39:0] HELLO = 40'h55544E7632;
  localparam logic [39:0] OK    = 40'h4F4B000000;
  localparam logic [39:0] ERR   = 40'h4552520000;

  initial begin
    vecs[0] = '{3'd4, 32'h5541544E, 3'd0, 40'h0, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{3'd4, 32'h5555544E, 3'd5, HELLO, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[2] = '{3'd2, 32'h1F400000, 3'd2, OK, 1'b1, 1'b0, 3'd7, 1'b1};
    vecs[3] = '{3'd3, 32'h55544E00, 3'd5, HELLO, 1'b0, 1'b1, 3'd7, 1'b0};
    vecs[4] = '{3'd2, 32'h30390000, 3'd3, ERR, 1'b0, 1'b1, 3'd7, 1'b0};
    vecs[5] = '{3'd3, 32'h55544E00, 3'd5, HELLO, 1'b0, 1'b1, 3'd7, 1'b0};
    vecs[6] = '{3'd2, 32'hAC440000, 3'd2, OK, 1'b1, 1'b0, 3'd1, 1'b1};
    vecs[7] = '{3'd3, 32'h55544E00, 3'd5, HELLO, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[8] = '{3'd2, 32'h5DC00000, 3'd2, OK, 1'b1, 1'b0, 3'd3, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst rx_st", 32'(rx_st), 32'd0);
    check("rst tx_rq", 32'(tx_rq), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst stream_en", 32'(stream_en), 32'd0);
    check("rst rate_sel", 32'(rate_sel), 32'd0);
    check("rst alarm", 32'(alarm), 32'd1);
    check("rst init_rdy", 32'(init_rdy), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) run_vec(i);

    // Streaming with regular strobes survives past the grace window.
    for (int c = 0; c < GR + 3 * WD; c++) begin
      sample_stb = (c % 40 == 0);
      @(posedge clk); #1;
    end
    sample_stb = 1'b0;
    check("wd_fed stream_en", 32'(stream_en), 32'd1);
    check("wd_fed alarm", 32'(alarm), 32'd0);

    // Last strobe, then exactly WD cycles to the trip.
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    for (int i = 1; i <= WD; i++) begin
      @(posedge clk); #1;
      if (i == WD - 1) check("wd_pre alarm", 32'(alarm), 32'd0);
    end
    check("wd_trip alarm", 32'(alarm), 32'd1);
    check("wd_trip stream_en", 32'(stream_en), 32'd0);
    check("wd_trip rate_sel", 32'(rate_sel), 32'd7);

    for (int i = 3; i < 7; i++) run_vec(i);

    // No strobes at all: grace holds the link up, then it trips.
    repeat (GR - 40) @(posedge clk);
    #1;
    check("grace stream_en", 32'(stream_en), 32'd1);
    check("grace alarm", 32'(alarm), 32'd0);
    rn = 0;
    while (!alarm && rn < WD + 100) begin
      @(posedge clk); #1;
      rn++;
    end
    check("grace_trip alarm", 32'(alarm), 32'd1);
    check("grace_trip stream_en", 32'(stream_en), 32'd0);

    // Byte timeout in GOT_T: the late 'N' must not start a hello.
    send_byte(8'h55);
    send_byte(8'h54);
    repeat (2 * BT) @(posedge clk);
    #1;
    send_byte(8'h4E);
    wait_drain();
    // A gap well under the timeout still completes the hello.
    push_tx(3'd5, HELLO);
    send_byte(8'h55);
    send_byte(8'h54);
    repeat (BT / 2) @(posedge clk);
    #1;
    send_byte(8'h4E);
    wait_drain();
    // RX_RATE_H times out, so a new UTN is a hello, not a rate.
    repeat (2 * BT) @(posedge clk);
    #1;
    push_tx(3'd5, HELLO);
    send_byte(8'h55);
    send_byte(8'h54);
    send_byte(8'h4E);
    wait_drain();
    check("tmo rate_sel", 32'(rate_sel), 32'd1);
    repeat (2 * BT) @(posedge clk);
    #1;

    // Reset while the hello is on the wire.
    push_tx(3'd5, HELLO);
    send_byte(8'h55);
    send_byte(8'h54);
    send_byte(8'h4E);
    rn = 0;
    while (!tx_rq && rn < 200) begin
      @(posedge clk); #1;
      rn++;
    end
    check("mid_tx tx_rq", 32'(tx_rq), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst tx_rq", 32'(tx_rq), 32'd0);
    check("arst rx_st", 32'(rx_st), 32'd0);
    check("arst tx_data", 32'(tx_data), 32'd0);
    check("arst rate_sel", 32'(rate_sel), 32'd0);
    check("arst alarm", 32'(alarm), 32'd1);
    check("arst stream_en", 32'(stream_en), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_vec(7);
    run_vec(8);

    check("tx_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
